// File: rtl/thread_scheduler_pkg.sv
// Shared CPU definitions used by the thread scheduler.
// Holds the per-thread run-state encoding, the default start PC and the fetch stride.
package thread_scheduler_pkg;

    typedef enum logic {
        THREAD_IDLE = 1'b0,
        THREAD_RUN  = 1'b1
    } thread_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
// Grants the first requester strictly after last_i, wrapping from NUM_THREADS-1 back to 0.
module rr_arbiter #(
    parameter int NUM_THREADS  = 8,
    parameter int BITS_THREADS = $clog2(NUM_THREADS)
) (
    input  logic [NUM_THREADS-1:0]  req_i,
    input  logic [BITS_THREADS-1:0] last_i,
    output logic [NUM_THREADS-1:0]  grant_o,
    output logic                    valid_o
);

    localparam int            IW = BITS_THREADS + 1;
    localparam logic [IW-1:0] NT = IW'(NUM_THREADS);

    logic [IW-1:0] cand;

    // Offset 1..N from the last grant, so the last winner is considered last.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int off = 1; off <= NUM_THREADS; off++) begin
            cand = {1'b0, last_i} + IW'(off);
            if (cand >= NT) begin
                cand = cand - NT;
            end
            if (!valid_o && req_i[cand[BITS_THREADS-1:0]]) begin
                grant_o[cand[BITS_THREADS-1:0]] = 1'b1;
                valid_o                         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Round-robin fetch scheduler: tracks run state, PC and in-flight status for every hardware
// thread and registers at most one fetch request per cycle.
module thread_scheduler
    import thread_scheduler_pkg::*;
#(
    parameter int                       NUM_THREADS   = 8,
    parameter int                       BITS_THREADS  = $clog2(NUM_THREADS),
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     start_valid,
    input  logic [BITS_THREADS-1:0]  start_tid,
    input  logic [ADDRESS_WIDTH-1:0] start_pc,
    input  logic                     halt_valid,
    input  logic [BITS_THREADS-1:0]  halt_tid,
    input  logic                     redirect_valid,
    input  logic [BITS_THREADS-1:0]  redirect_tid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     retire_valid,
    input  logic [BITS_THREADS-1:0]  retire_tid,
    output logic                     issue_valid,
    output logic [BITS_THREADS-1:0]  issue_tid,
    output logic [ADDRESS_WIDTH-1:0] issue_pc,
    output logic [NUM_THREADS-1:0]   active_mask
);

    thread_state_e            state_q [NUM_THREADS];
    thread_state_e            state_d [NUM_THREADS];
    logic [ADDRESS_WIDTH-1:0] pc_q    [NUM_THREADS];
    logic [ADDRESS_WIDTH-1:0] pc_d    [NUM_THREADS];
    logic [NUM_THREADS-1:0]   in_flight_q, in_flight_d;
    logic [NUM_THREADS-1:0]   halt_pending_q, halt_pending_d;
    logic [BITS_THREADS-1:0]  last_tid_q, last_tid_d;
    logic                     issue_valid_q, issue_valid_d;
    logic [BITS_THREADS-1:0]  issue_tid_q, issue_tid_d;
    logic [ADDRESS_WIDTH-1:0] issue_pc_q, issue_pc_d;

    logic [NUM_THREADS-1:0]   run_mask;
    logic [NUM_THREADS-1:0]   start_hit;
    logic [NUM_THREADS-1:0]   halt_hit;
    logic [NUM_THREADS-1:0]   redirect_hit;
    logic [NUM_THREADS-1:0]   retire_hit;
    logic [NUM_THREADS-1:0]   eligible;
    logic [NUM_THREADS-1:0]   grant;
    logic                     grant_valid;
    logic                     pick;
    logic [BITS_THREADS-1:0]  pick_tid;

    always_comb begin
        run_mask     = '0;
        start_hit    = '0;
        halt_hit     = '0;
        redirect_hit = '0;
        retire_hit   = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            run_mask[i]     = (state_q[i] == THREAD_RUN);
            start_hit[i]    = start_valid    && (start_tid    == BITS_THREADS'(i));
            halt_hit[i]     = halt_valid     && (halt_tid     == BITS_THREADS'(i));
            redirect_hit[i] = redirect_valid && (redirect_tid == BITS_THREADS'(i));
            retire_hit[i]   = retire_valid   && (retire_tid   == BITS_THREADS'(i));
        end
    end

    // A same-cycle halt already excludes the thread, so a halt never races a pick.
    assign eligible = run_mask & ~in_flight_q & ~halt_pending_q & ~halt_hit;
    assign pick     = grant_valid && !stall;

    rr_arbiter #(
        .NUM_THREADS  (NUM_THREADS),
        .BITS_THREADS (BITS_THREADS)
    ) u_rr_arbiter (
        .req_i   (eligible),
        .last_i  (last_tid_q),
        .grant_o (grant),
        .valid_o (grant_valid)
    );

    always_comb begin
        pick_tid = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (grant[i]) begin
                pick_tid = BITS_THREADS'(i);
            end
        end
    end

    // Later assignments take precedence: redirect beats the pick's PC+4, halt beats start.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        in_flight_d    = in_flight_q;
        halt_pending_d = halt_pending_q;
        last_tid_d     = last_tid_q;
        issue_valid_d  = pick;
        issue_tid_d    = issue_tid_q;
        issue_pc_d     = issue_pc_q;
        if (pick) begin
            issue_tid_d = pick_tid;
            issue_pc_d  = pc_q[pick_tid];
            last_tid_d  = pick_tid;
        end
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (pick && grant[i]) begin
                in_flight_d[i] = 1'b1;
                pc_d[i]        = pc_q[i] + ADDRESS_WIDTH'(PC_STEP);
            end
            if (retire_hit[i]) begin
                in_flight_d[i] = 1'b0;
                if (halt_pending_q[i]) begin
                    state_d[i]        = THREAD_IDLE;
                    halt_pending_d[i] = 1'b0;
                end
            end
            if (redirect_hit[i]) begin
                pc_d[i] = redirect_pc;
            end
            if (start_hit[i] && !halt_hit[i] && !run_mask[i]) begin
                state_d[i] = THREAD_RUN;
                pc_d[i]    = start_pc;
            end
            if (halt_hit[i] && run_mask[i]) begin
                if (!in_flight_q[i] || retire_hit[i]) begin
                    state_d[i]        = THREAD_IDLE;
                    halt_pending_d[i] = 1'b0;
                end else begin
                    halt_pending_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                state_q[i] <= (i == 0) ? THREAD_RUN : THREAD_IDLE;
                pc_q[i]    <= (i == 0) ? RESET_PC : '0;
            end
            in_flight_q    <= '0;
            halt_pending_q <= '0;
            last_tid_q     <= BITS_THREADS'(NUM_THREADS - 1);
            issue_valid_q  <= 1'b0;
            issue_tid_q    <= '0;
            issue_pc_q     <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            in_flight_q    <= in_flight_d;
            halt_pending_q <= halt_pending_d;
            last_tid_q     <= last_tid_d;
            issue_valid_q  <= issue_valid_d;
            issue_tid_q    <= issue_tid_d;
            issue_pc_q     <= issue_pc_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_tid   = issue_tid_q;
    assign issue_pc    = issue_pc_q;
    assign active_mask = run_mask;

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: a per-thread behavioural model is compared against
// the DUT every cycle, with an automatic retire four edges after each issue, plus literal checks.
module tb_thread_scheduler;

    localparam int          NT       = 8;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        start_valid;
    logic [2:0]  start_tid;
    logic [31:0] start_pc;
    logic        halt_valid;
    logic [2:0]  halt_tid;
    logic        redirect_valid;
    logic [2:0]  redirect_tid;
    logic [31:0] redirect_pc;
    logic        retire_valid;
    logic [2:0]  retire_tid;
    logic        issue_valid;
    logic [2:0]  issue_tid;
    logic [31:0] issue_pc;
    logic [7:0]  active_mask;

    thread_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .start_valid    (start_valid),
        .start_tid      (start_tid),
        .start_pc       (start_pc),
        .halt_valid     (halt_valid),
        .halt_tid       (halt_tid),
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .redirect_pc    (redirect_pc),
        .retire_valid   (retire_valid),
        .retire_tid     (retire_tid),
        .issue_valid    (issue_valid),
        .issue_tid      (issue_tid),
        .issue_pc       (issue_pc),
        .active_mask    (active_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    bit          mRun   [NT];
    logic [31:0] mPc    [NT];
    bit          mInf   [NT];
    bit          mHaltP [NT];
    int          mLast;
    bit          mValid;
    int          mTid;
    logic [31:0] mIssuePc;
    bit          mReset;

    int          rqTid [$];
    int          rqDue [$];
    int          logTid [$];
    logic [31:0] logPc  [$];
    int          logCyc [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int logTidAt(input int idx);
        return (idx < logTid.size()) ? logTid[idx] : -1;
    endfunction

    function automatic logic [31:0] logPcAt(input int idx);
        return (idx < logPc.size()) ? logPc[idx] : 32'hDEAD_BEEF;
    endfunction

    function automatic int logCycAt(input int idx);
        return (idx < logCyc.size()) ? logCyc[idx] : -1000;
    endfunction

    // Model of one rising edge, written directly from the scheduling rules.
    task automatic modelStep();
        bit oldRun [NT];
        bit oldInf [NT];
        int t;
        int pickT;
        if (rst !== 1'b1) begin
            for (int i = 0; i < NT; i++) begin
                mRun[i]   = (i == 0);
                mPc[i]    = (i == 0) ? RESET_PC : 32'h0;
                mInf[i]   = 1'b0;
                mHaltP[i] = 1'b0;
            end
            mLast    = NT - 1;
            mValid   = 1'b0;
            mTid     = 0;
            mIssuePc = 32'h0;
            mReset   = 1'b1;
            return;
        end
        mReset = 1'b0;
        oldRun = mRun;
        oldInf = mInf;
        pickT  = -1;
        if (!stall) begin
            for (int k = 1; k <= NT; k++) begin
                t = (mLast + k) % NT;
                if (pickT < 0 && mRun[t] && !mInf[t] && !mHaltP[t]
                    && !(halt_valid && int'(halt_tid) == t)) begin
                    pickT = t;
                end
            end
        end
        mValid = (pickT >= 0);
        if (mValid) begin
            mTid        = pickT;
            mIssuePc    = mPc[pickT];
            mPc[pickT]  = mPc[pickT] + 32'd4;
            mInf[pickT] = 1'b1;
            mLast       = pickT;
        end
        if (retire_valid) begin
            mInf[retire_tid] = 1'b0;
            if (mHaltP[retire_tid]) begin
                mRun[retire_tid]   = 1'b0;
                mHaltP[retire_tid] = 1'b0;
            end
        end
        if (redirect_valid) mPc[redirect_tid] = redirect_pc;
        if (start_valid && !oldRun[start_tid] && !(halt_valid && halt_tid == start_tid)) begin
            mRun[start_tid] = 1'b1;
            mPc[start_tid]  = start_pc;
        end
        if (halt_valid && oldRun[halt_tid]) begin
            if (!oldInf[halt_tid] || (retire_valid && retire_tid == halt_tid)) begin
                mRun[halt_tid]   = 1'b0;
                mHaltP[halt_tid] = 1'b0;
            end else begin
                mHaltP[halt_tid] = 1'b1;
            end
        end
    endtask

    // One clock: auto-retire, edge, model update, per-cycle compare, bookkeeping.
    task automatic tick();
        bit         drove;
        logic [7:0] expMask;
        drove = 1'b0;
        if (rqTid.size() > 0 && rqDue[0] <= cyc + 1 && rst === 1'b1) begin
            retire_valid = 1'b1;
            retire_tid   = 3'(rqTid[0]);
            drove        = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        modelStep();
        expMask = '0;
        for (int i = 0; i < NT; i++) expMask[i] = mRun[i];
        checkOutput("issue_valid", 32'(issue_valid), 32'(mValid));
        if (mValid || mReset) begin
            checkOutput("issue_tid", 32'(issue_tid), 32'(mTid));
            checkOutput("issue_pc", issue_pc, mIssuePc);
        end
        checkOutput("active_mask", 32'(active_mask), 32'(expMask));
        if (issue_valid === 1'b1) begin
            logTid.push_back(int'(issue_tid));
            logPc.push_back(issue_pc);
            logCyc.push_back(cyc);
        end
        if (drove) begin
            void'(rqTid.pop_front());
            void'(rqDue.pop_front());
        end
        if (rst !== 1'b1) begin
            rqTid.delete();
            rqDue.delete();
        end
        if (mValid) begin
            rqTid.push_back(mTid);
            rqDue.push_back(cyc + 4);
        end
        retire_valid   = 1'b0;
        start_valid    = 1'b0;
        halt_valid     = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic applyStimulus(input bit sv, input int st, input logic [31:0] sp,
                                 input bit hv, input int ht,
                                 input bit rv, input int rt, input logic [31:0] rp);
        start_valid    = sv;
        start_tid      = 3'(st);
        start_pc       = sp;
        halt_valid     = hv;
        halt_tid       = 3'(ht);
        redirect_valid = rv;
        redirect_tid   = 3'(rt);
        redirect_pc    = rp;
        tick();
    endtask

    task automatic runCycles(input int n);
        repeat (n) tick();
    endtask

    // Ticks at least once, until the model shows a fresh issue of tid; bounded.
    task automatic waitModelIssue(input int tid, input int budget, input string what);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(mValid && mTid == tid) && n < budget);
        if (!(mValid && mTid == tid)) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s: no issue of thread %0d within %0d cycles", what, tid, budget);
        end
    endtask

    initial begin
        int s;
        int cnt;
        rst            = 1'b0;
        stall          = 1'b0;
        start_valid    = 1'b0;
        start_tid      = '0;
        start_pc       = '0;
        halt_valid     = 1'b0;
        halt_tid       = '0;
        redirect_valid = 1'b0;
        redirect_tid   = '0;
        redirect_pc    = '0;
        retire_valid   = 1'b0;
        retire_tid     = '0;

        runCycles(2);
        checkOutput("reset active_mask", 32'(active_mask), 32'h01);
        checkOutput("reset issue_valid", 32'(issue_valid), 32'h0);
        checkOutput("reset issue_pc", issue_pc, 32'h0);

        $display("[TB] single thread cadence");
        rst = 1'b1;
        s = logTid.size();
        runCycles(16);
        checkOutput("t0 first pc", logPcAt(s), 32'h0);
        checkOutput("t0 second pc", logPcAt(s + 1), 32'h4);
        checkOutput("t0 third pc", logPcAt(s + 2), 32'h8);
        checkOutput("t0 third tid", 32'(logTidAt(s + 2)), 32'h0);
        checkOutput("t0 spacing 1", 32'(logCycAt(s + 1) - logCycAt(s)), 32'd5);
        checkOutput("t0 spacing 2", 32'(logCycAt(s + 2) - logCycAt(s + 1)), 32'd5);

        $display("[TB] start/halt corner cases");
        applyStimulus(1, 5, 32'h500, 1, 5, 0, 0, 0);
        checkOutput("start+halt same tid", 32'(active_mask), 32'h01);
        applyStimulus(0, 0, 0, 1, 6, 0, 0, 0);
        checkOutput("halt idle thread", 32'(active_mask), 32'h01);
        applyStimulus(1, 0, 32'h999, 0, 0, 0, 0, 0);
        runCycles(12);

        $display("[TB] eight-thread round robin");
        rst   = 1'b0;
        stall = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 1; i < NT; i++) applyStimulus(1, i, 32'(i * 32'h100), 0, 0, 0, 0, 0);
        checkOutput("all started mask", 32'(active_mask), 32'hFF);
        stall = 1'b0;
        s = logTid.size();
        runCycles(12);
        for (int k = 0; k < 9; k++) checkOutput("rr tid order", 32'(logTidAt(s + k)), 32'(k % NT));
        checkOutput("rr no bubble", 32'(logCycAt(s + 8) - logCycAt(s)), 32'd8);
        checkOutput("t3 first pc", logPcAt(s + 3), 32'h300);
        checkOutput("t3 second tid", 32'(logTidAt(s + 11)), 32'd3);
        checkOutput("t3 second pc", logPcAt(s + 11), 32'h304);

        $display("[TB] stall window");
        stall = 1'b1;
        s = logTid.size();
        runCycles(3);
        checkOutput("stall issues", 32'(logTid.size() - s), 32'd0);
        stall = 1'b0;
        tick();
        checkOutput("pre-stall tid", 32'(logTidAt(s - 1)), 32'd3);
        checkOutput("resume tid", 32'(logTidAt(s)), 32'd4);

        $display("[TB] redirect");
        waitModelIssue(2, 20, "redirect setup");
        applyStimulus(0, 0, 0, 0, 0, 1, 2, 32'h80);
        waitModelIssue(2, 20, "redirect reissue");
        checkOutput("redirect pc", issue_pc, 32'h80);

        $display("[TB] halt while in flight");
        waitModelIssue(1, 20, "halt setup");
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("halt pending mask bit", 32'(active_mask[1]), 32'h1);
        s = logTid.size();
        runCycles(20);
        checkOutput("halted mask", 32'(active_mask), 32'hFD);
        cnt = 0;
        for (int k = s; k < logTid.size(); k++) if (logTid[k] == 1) cnt++;
        checkOutput("halted reissue count", 32'(cnt), 32'd0);
        applyStimulus(1, 1, 32'h40, 0, 0, 0, 0, 0);
        waitModelIssue(1, 20, "restart");
        checkOutput("restart pc", issue_pc, 32'h40);
        checkOutput("restart mask", 32'(active_mask), 32'hFF);

        $display("[TB] PC wrap and mid-run reset");
        waitModelIssue(4, 20, "wrap setup");
        applyStimulus(0, 0, 0, 0, 0, 1, 4, 32'hFFFF_FFFC);
        waitModelIssue(4, 20, "wrap first");
        checkOutput("wrap top pc", issue_pc, 32'hFFFF_FFFC);
        waitModelIssue(4, 20, "wrap second");
        checkOutput("wrap zero pc", issue_pc, 32'h0);
        rst = 1'b0;
        applyStimulus(1, 6, 32'h600, 1, 0, 1, 0, 32'h500);
        checkOutput("mid reset mask", 32'(active_mask), 32'h01);
        checkOutput("mid reset valid", 32'(issue_valid), 32'h0);
        rst = 1'b1;
        tick();
        checkOutput("post reset valid", 32'(issue_valid), 32'h1);
        checkOutput("post reset tid", 32'(issue_tid), 32'h0);
        checkOutput("post reset pc", issue_pc, RESET_PC);
        runCycles(6);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
